mod_n_updown_counter: RTL

//   Parametrised modulo-N up/down counter for the clock's time-keeping chain
//   (seconds, minutes, hours, prescalers). Runtime-programmable limit, enable
//   (carry-in), synchronous clear/load, wrap or saturate mode, and registered

---
 rtl/mod_n_updown_counter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter for the time-keeping chain.
// Wrap or saturate mode, registered carry/borrow pulses for cascading.
module mod_n_updown_counter #(
    parameter int WIDTH   = 8,
    parameter int MODE    = 0,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_count,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover,
    output logic             borrow,
    output logic             at_limit,
    output logic             saturated
);

    localparam logic [WIDTH-1:0] LP_RST = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);
    localparam logic             LP_SAT = (MODE != 0);

    logic [WIDTH-1:0] r_count;
    logic             r_roll;
    logic             r_bor;
    logic             r_sat;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_roll_nxt;
    logic             w_bor_nxt;
    logic             w_sat_nxt;

    logic [WIDTH-1:0] w_load_clamp;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             w_at_top;
    logic             w_above;
    logic             w_at_zero;

    logic             w_do_clr;
    logic             w_do_load;
    logic             w_do_step;

    // Mutually exclusive action selects: clear beats load beats enable.
    assign w_do_clr  = clear;
    assign w_do_load = load & ~clear;
    assign w_do_step = en & ~clear & ~load;

    // Datapath helpers; a value above a lowered limit counts as "at top".
    assign w_load_clamp = (load_val > limit) ? limit : load_val;
    assign w_inc        = r_count + LP_ONE;
    assign w_dec        = r_count - LP_ONE;
    assign w_at_top     = (r_count >= limit);
    assign w_above      = (r_count > limit);
    assign w_at_zero    = (r_count == '0);

    // Next-state selection for count and the flag registers.
    always_comb begin
        w_count_nxt = r_count;
        w_roll_nxt  = 1'b0;
        w_bor_nxt   = 1'b0;
        w_sat_nxt   = r_sat;
        unique case (1'b1)
            w_do_clr: begin
                w_count_nxt = '0;
                w_sat_nxt   = 1'b0;
            end
            w_do_load: begin
                w_count_nxt = w_load_clamp;
                w_sat_nxt   = 1'b0;
            end
            w_do_step: begin
                if (up_dn) begin
                    if (!w_at_top) begin
                        w_count_nxt = w_inc;
                        w_sat_nxt   = 1'b0;
                    end else if (LP_SAT) begin
                        w_count_nxt = limit;
                        w_sat_nxt   = 1'b1;
                    end else begin
                        w_count_nxt = '0;
                        w_roll_nxt  = 1'b1;
                        w_sat_nxt   = 1'b0;
                    end
                end else begin
                    if (w_above) begin
                        w_count_nxt = limit;
                        w_sat_nxt   = 1'b0;
                    end else if (!w_at_zero) begin
                        w_count_nxt = w_dec;
                        w_sat_nxt   = 1'b0;
                    end else if (LP_SAT) begin
                        w_count_nxt = '0;
                        w_sat_nxt   = 1'b1;
                    end else begin
                        w_count_nxt = limit;
                        w_bor_nxt   = 1'b1;
                        w_sat_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            r_count <= LP_RST;
            r_roll  <= 1'b0;
            r_bor   <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_roll  <= w_roll_nxt;
            r_bor   <= w_bor_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    assign count_out = r_count;
    assign rollover  = r_roll;
    assign borrow    = r_bor;
    assign saturated = r_sat;
    assign at_limit  = (r_count == limit);

endmodule
